odo_fuel_tracker: RTL and testbench
===================================

Name: odo_fuel_tracker

Overview:
- Vehicle-state integrator sitting directly upstream of the dashboard LCD driver.
- Integrates speed over time into an odometer (km) and burns fuel into a 0..100 % gauge.
- Supports refuelling while the engine is off.
- Its `odometer`, `fuel` and `fuel_low` outputs feed the LCD driver's odometer/fuel inputs without conversion.

Parameters:
- TICK_CYCLES, 50_000_000: clk cycles per integration tick (1 s at 50 MHz).
- ODO_INIT, 0: odometer value after reset, km.
- ODO_MAX, 99999: largest odometer value; the next km wraps to 0.
- FUEL_INIT, 100: fuel % after reset.
- FUEL_MAX, 100: refuel ceiling, %.
- FUEL_LOW_TH, 15: `fuel_low` asserted when fuel < this.
- IDLE_BURN, 2: burn units added per tick while running, regardless of speed.
- BURN_PER_PCT, 1000: burn units per 1 % of fuel. Must be > 255 + IDLE_BURN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- engine_on  in  1  engine running
- is_side_brake  in  1  parking brake engaged; forces effective speed to 0
- speed  in  8  current speed, km/h
- refuel_req  in  1  level; hold to refuel
- trip_reset  in  1  one-cycle pulse; clears trip meter (TRIP_METER_EN only)
- odometer  out  32  total distance, km
- fuel  out  8  fuel level, 0..FUEL_MAX %
- fuel_low  out  1  fuel < FUEL_LOW_TH
- fuel_empty  out  1  fuel == 0
- km_tick  out  1  one-cycle pulse on each odometer increment
- trip_dkm  out  16  trip distance in 0.1 km units

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values:
  - odometer = ODO_INIT, fuel = FUEL_INIT.
  - fuel_low and fuel_empty are registered from the reset fuel value.
  - km_tick = 0, trip_dkm = 0.
  - Tick counter, dist_acc, burn_acc and tenth_cnt = 0.
  - state = S_OFF.
- Tick generator:
  - tick_cnt runs 0..TICK_CYCLES-1 continuously, including while the engine is off.
  - `tick` is high for the one cycle where tick_cnt == TICK_CYCLES-1.
  - Reset mid-count restarts the count at 0.
- Effective speed: eff = 0 if is_side_brake, else speed.
- FSM:
  - S_OFF → S_RUN when engine_on && fuel > 0.
  - S_OFF → S_STARVED when engine_on && fuel == 0.
  - S_OFF → S_REFUEL when !engine_on && refuel_req && fuel < FUEL_MAX.
  - S_RUN → S_OFF when !engine_on.
  - S_RUN → S_STARVED when fuel reaches 0.
  - S_STARVED → S_OFF when !engine_on. There is no exit to S_RUN without an engine cycle.
  - S_REFUEL → S_OFF when refuel_req drops, or engine_on rises, or fuel == FUEL_MAX.
  - engine_on takes priority over refuel_req.
- S_RUN, on each tick:
  - Distance: s = dist_acc + eff. If s ≥ 360, then dist_acc = s − 360 and a 0.1 km event fires; otherwise dist_acc = s. Since eff ≤ 255, at most one event fires per tick.
  - On each 0.1 km event: tenth_cnt increments. On the 9→0 rollover, odometer increments and km_tick pulses.
  - Odometer at ODO_MAX wraps to 0, and km_tick still pulses.
  - Fuel: b = burn_acc + eff + IDLE_BURN. If b ≥ BURN_PER_PCT, then burn_acc = b − BURN_PER_PCT and fuel decrements by 1, saturating at 0.
  - A distance event and a fuel decrement on the same tick both take effect.
  - The tick that takes fuel to 0 still applies its distance event. State becomes S_STARVED on the next cycle.
- S_STARVED and S_OFF: dist_acc, burn_acc, tenth_cnt, odometer and fuel all hold. Accumulators are not cleared on engine off.
- S_REFUEL: on each tick, fuel increments by 1, saturating at FUEL_MAX.
- Latency: odometer, fuel and km_tick update on the clk edge after the tick cycle. fuel_low and fuel_empty follow one cycle after fuel.
- All arithmetic is unsigned. dist_acc is 9 bits; burn_acc is wide enough for 2×BURN_PER_PCT.

Optional Feature:
- Macro: TRIP_METER_EN.
- Defined:
  - trip_dkm increments on every 0.1 km event, saturating at 65535.
  - trip_reset clears trip_dkm to 0 the next cycle.
  - If trip_reset and a 0.1 km event occur in the same cycle, trip_reset wins and the result is 0.
- Undefined:
  - trip_dkm is tied to 0 and trip_reset is ignored.
  - No trip register is synthesised.
- Ports exist in both builds.

Test Plan:
- Reset check: assert rst for 3 cycles with defaults → odometer = 0, fuel = 100, fuel_low = 0, fuel_empty = 0, state = S_OFF.
- Distance: TICK_CYCLES = 10, engine_on = 1, speed = 36 for 1000 cycles (100 ticks) → odometer = 1, exactly one km_tick pulse; with TRIP_METER_EN, trip_dkm = 10. Then set is_side_brake = 1 for 100 ticks → odometer stays at 1.
- Idle burn: TICK_CYCLES = 10, speed = 0 → fuel drops by 1 every 500 ticks; fuel_low asserts the cycle after fuel becomes 14.
- Starvation: fuel preloaded to 1, speed = 255 → fuel reaches 0, fuel_empty = 1, state = S_STARVED, odometer frozen. Then set engine_on = 0 → state = S_OFF.
- Refuel:
  - refuel_req = 1 with engine_on = 1 → fuel unchanged.
  - engine_on = 0, refuel_req held for 50 ticks from fuel = 0 → fuel = 50.
  - Held for 200 ticks → fuel saturates at 100 and state returns to S_OFF.
- Wrap: ODO_INIT = 99999, speed = 36 for 100 ticks → odometer = 0, km_tick pulses once. With TRIP_METER_EN, a trip_reset coincident with a 0.1 km event → trip_dkm = 0.

Source files
------------

// File: rtl/odo_fuel_tracker.sv
// odo_fuel_tracker: integrates speed into odometer/trip distance and burns fuel into a % gauge; optional trip meter via TRIP_METER_EN
module odo_fuel_tracker #(
    parameter int unsigned TICK_CYCLES  = 50_000_000,
    parameter int unsigned ODO_INIT     = 0,
    parameter int unsigned ODO_MAX      = 99999,
    parameter int unsigned FUEL_INIT    = 100,
    parameter int unsigned FUEL_MAX     = 100,
    parameter int unsigned FUEL_LOW_TH  = 15,
    parameter int unsigned IDLE_BURN    = 2,
    parameter int unsigned BURN_PER_PCT = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        engine_on,
    input  logic        is_side_brake,
    input  logic [7:0]  speed,
    input  logic        refuel_req,
    input  logic        trip_reset,
    output logic [31:0] odometer,
    output logic [7:0]  fuel,
    output logic        fuel_low,
    output logic        fuel_empty,
    output logic        km_tick,
    output logic [15:0] trip_dkm
);
    localparam int TW = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;
    localparam int BW = $clog2(2 * BURN_PER_PCT + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [BW-1:0] BPP       = BW'(BURN_PER_PCT);
    localparam logic [7:0]    FMAX      = 8'(FUEL_MAX);
    localparam logic [7:0]    FLOW      = 8'(FUEL_LOW_TH);
    localparam logic [31:0]   OMAX      = 32'(ODO_MAX);

    typedef enum logic [1:0] {S_OFF, S_RUN, S_STARVED, S_REFUEL} state_t;

    state_t         state, state_nx;
    logic [TW-1:0]  tick_cnt;
    logic           tick;
    logic [8:0]     dist_acc;
    logic [BW-1:0]  burn_acc;
    logic [3:0]     tenth_cnt;
    logic [7:0]     eff;
    logic [9:0]     dist_sum;
    logic [BW-1:0]  burn_sum;
    logic           run_tick;
    logic           dkm;
    logic           burn_pct;

    assign tick     = tick_cnt == TICK_LAST;
    assign eff      = is_side_brake ? 8'd0 : speed;
    assign run_tick = tick && state == S_RUN;
    assign dist_sum = {1'b0, dist_acc} + {2'b00, eff};
    assign dkm      = run_tick && dist_sum >= 10'd360;
    assign burn_sum = burn_acc + BW'(eff) + BW'(IDLE_BURN);
    assign burn_pct = burn_sum >= BPP;

    // free-running integration tick, independent of engine state
    always_ff @(posedge clk) begin
        if (rst || tick) tick_cnt <= '0;
        else             tick_cnt <= tick_cnt + TW'(1);
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_OFF;
        else     state <= state_nx;
    end

    // next state: engine_on outranks refuel_req; starvation only clears through engine off
    always_comb begin
        state_nx = state;
        case (state)
            S_OFF:     state_nx = engine_on ? (fuel != 8'd0 ? S_RUN : S_STARVED)
                                            : (refuel_req && fuel < FMAX ? S_REFUEL : S_OFF);
            S_RUN:     state_nx = !engine_on ? S_OFF : (fuel == 8'd0 ? S_STARVED : S_RUN);
            S_STARVED: state_nx = engine_on ? S_STARVED : S_OFF;
            S_REFUEL:  state_nx = (!refuel_req || engine_on || fuel >= FMAX) ? S_OFF : S_REFUEL;
            default:   state_nx = S_OFF;
        endcase
    end

    // distance and fuel integration; accumulators hold outside S_RUN
    always_ff @(posedge clk) begin
        if (rst) begin
            dist_acc  <= '0;
            burn_acc  <= '0;
            tenth_cnt <= '0;
            odometer  <= 32'(ODO_INIT);
            fuel      <= 8'(FUEL_INIT);
            km_tick   <= 1'b0;
        end else begin
            km_tick <= dkm && tenth_cnt == 4'd9;
            if (run_tick) begin
                dist_acc <= dkm ? 9'(dist_sum - 10'd360) : dist_sum[8:0];
                burn_acc <= burn_pct ? burn_sum - BPP : burn_sum;
                if (dkm) tenth_cnt <= tenth_cnt == 4'd9 ? 4'd0 : tenth_cnt + 4'd1;
                if (dkm && tenth_cnt == 4'd9) odometer <= odometer >= OMAX ? 32'd0 : odometer + 32'd1;
                if (burn_pct && fuel != 8'd0) fuel <= fuel - 8'd1;
            end else if (tick && state == S_REFUEL && fuel < FMAX) begin
                fuel <= fuel + 8'd1;
            end
        end
    end

    // gauge flags trail the fuel register by one cycle
    always_ff @(posedge clk) begin
        fuel_low   <= rst ? FUEL_INIT < FUEL_LOW_TH : fuel < FLOW;
        fuel_empty <= rst ? FUEL_INIT == 0 : fuel == 8'd0;
    end

`ifdef TRIP_METER_EN
    // trip meter in 0.1 km units; a coincident trip_reset beats the increment
    always_ff @(posedge clk) begin
        if (rst || trip_reset)             trip_dkm <= '0;
        else if (dkm && trip_dkm != '1)    trip_dkm <= trip_dkm + 16'd1;
    end
`else
    logic unused_trip;
    assign unused_trip = trip_reset;
    assign trip_dkm    = '0;
`endif
endmodule

// File: tb/tb_odo_fuel_tracker.sv
// tb_odo_fuel_tracker: scoreboard bench for odo_fuel_tracker with fast ticks and a wrap-preset twin
module tb_odo_fuel_tracker;
    localparam int TC = 10;
`ifdef TRIP_METER_EN
    localparam bit TRIP = 1'b1;
`else
    localparam bit TRIP = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1, engine_on = 1'b0, is_side_brake = 1'b0, refuel_req = 1'b0, trip_reset = 1'b0;
    logic [7:0]  speed = 8'd0;
    logic [31:0] odo_a, odo_b;
    logic [7:0]  fuel_a, fuel_b;
    logic        low_a, low_b, empty_a, empty_b, kt_a, kt_b;
    logic [15:0] trip_a, trip_b;

    int total = 0, bad = 0, phase = 0, km_a = 0, km_b = 0;
    int unsigned q_a[$], q_b[$];
    int unsigned e_a, e_b;
    int m_fuel, m_burn, m_dist, m_tenth, m_trip, m_state;
    int unsigned m_odo_a, m_odo_b;

    odo_fuel_tracker #(.TICK_CYCLES(TC)) dut_a (
        .clk(clk), .rst(rst), .engine_on(engine_on), .is_side_brake(is_side_brake), .speed(speed),
        .refuel_req(refuel_req), .trip_reset(trip_reset), .odometer(odo_a), .fuel(fuel_a),
        .fuel_low(low_a), .fuel_empty(empty_a), .km_tick(kt_a), .trip_dkm(trip_a));

    odo_fuel_tracker #(.TICK_CYCLES(TC), .ODO_INIT(99999)) dut_b (
        .clk(clk), .rst(rst), .engine_on(engine_on), .is_side_brake(is_side_brake), .speed(speed),
        .refuel_req(refuel_req), .trip_reset(trip_reset), .odometer(odo_b), .fuel(fuel_b),
        .fuel_low(low_b), .fuel_empty(empty_b), .km_tick(kt_b), .trip_dkm(trip_b));

    always #5 clk = ~clk;

    // bench's own view of the tick phase
    always @(posedge clk) phase <= rst ? 0 : (phase == TC - 1 ? 0 : phase + 1);

    // km_tick scoreboard: each pulse must match the next expected odometer value
    always @(negedge clk) begin
        if (!rst && kt_a) begin
            km_a++;
            total++;
            if (q_a.size() == 0) begin
                bad++;
                $display("FAIL km_a unexpected pulse odometer=%0d", odo_a);
            end else begin
                e_a = q_a.pop_front();
                if (odo_a !== e_a) begin bad++; $display("FAIL km_a odometer got=%0d want=%0d", odo_a, e_a); end
            end
        end
        if (!rst && kt_b) begin
            km_b++;
            total++;
            if (q_b.size() == 0) begin
                bad++;
                $display("FAIL km_b unexpected pulse odometer=%0d", odo_b);
            end else begin
                e_b = q_b.pop_front();
                if (odo_b !== e_b) begin bad++; $display("FAIL km_b odometer got=%0d want=%0d", odo_b, e_b); end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    function automatic int nxt(int s);
        case (s)
            0:       return engine_on ? (m_fuel > 0 ? 1 : 2) : (refuel_req && m_fuel < 100 ? 3 : 0);
            1:       return !engine_on ? 0 : (m_fuel == 0 ? 2 : 1);
            2:       return engine_on ? 2 : 0;
            default: return (!refuel_req || engine_on || m_fuel >= 100) ? 0 : 3;
        endcase
    endfunction

    task automatic model_init();
        m_fuel = 100; m_burn = 0; m_dist = 0; m_tenth = 0; m_trip = 0; m_state = 0;
        m_odo_a = 0; m_odo_b = 99999;
    endtask

    task automatic model_tick(input bit tp);
        int eff, s, b;
        for (int k = 0; k < 3; k++) m_state = nxt(m_state);
        eff = is_side_brake ? 0 : int'(speed);
        if (m_state == 1) begin
            s = m_dist + eff;
            m_dist = s >= 360 ? s - 360 : s;
            if (s >= 360) begin
                if (m_trip < 65535) m_trip++;
                if (m_tenth == 9) begin
                    m_tenth = 0;
                    m_odo_a = m_odo_a == 99999 ? 0 : m_odo_a + 1;
                    m_odo_b = m_odo_b == 99999 ? 0 : m_odo_b + 1;
                    q_a.push_back(m_odo_a);
                    q_b.push_back(m_odo_b);
                end else m_tenth++;
            end
            b = m_burn + eff + 2;
            m_burn = b >= 1000 ? b - 1000 : b;
            if (b >= 1000 && m_fuel > 0) m_fuel--;
        end else if (m_state == 3 && m_fuel < 100) m_fuel++;
        if (tp) m_trip = 0;
    endtask

    // advance to the tick cycle, apply the model, and return just after the tick edge
    task automatic one_tick(input bit tp);
        for (int k = 0; k < TC + 2 && phase != TC - 1; k++) @(negedge clk);
        trip_reset = tp;
        model_tick(tp);
        @(negedge clk);
        trip_reset = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total += 7;
        if (odo_a !== 32'd0)     begin bad++; $display("FAIL rst_odo_a got=%0d want=0", odo_a); end
        if (odo_b !== 32'd99999) begin bad++; $display("FAIL rst_odo_b got=%0d want=99999", odo_b); end
        if (fuel_a !== 8'd100)   begin bad++; $display("FAIL rst_fuel got=%0d want=100", fuel_a); end
        if (low_a !== 1'b0)      begin bad++; $display("FAIL rst_low got=%0b want=0", low_a); end
        if (empty_a !== 1'b0)    begin bad++; $display("FAIL rst_empty got=%0b want=0", empty_a); end
        if (kt_a !== 1'b0)       begin bad++; $display("FAIL rst_km_tick got=%0b want=0", kt_a); end
        if (trip_a !== 16'd0)    begin bad++; $display("FAIL rst_trip got=%0d want=0", trip_a); end
        rst = 1'b0;
        model_init();
        repeat (5) one_tick(1'b0);
        total++;
        if (fuel_a !== 8'd100 || odo_a !== 32'd0) begin
            bad++; $display("FAIL off_hold fuel=%0d odo=%0d want 100/0", fuel_a, odo_a);
        end
    endtask

    task automatic test_distance();
        int ka, kb;
        ka = km_a; kb = km_b;
        engine_on = 1'b1; speed = 8'd36;
        repeat (105) one_tick(1'b0);
        total += 6;
        if (odo_a !== 32'd1)  begin bad++; $display("FAIL dist_odo_a got=%0d want=1", odo_a); end
        if (odo_b !== 32'd0)  begin bad++; $display("FAIL wrap_odo_b got=%0d want=0", odo_b); end
        if (km_a - ka !== 1)  begin bad++; $display("FAIL dist_km_pulses_a got=%0d want=1", km_a - ka); end
        if (km_b - kb !== 1)  begin bad++; $display("FAIL wrap_km_pulses_b got=%0d want=1", km_b - kb); end
        if (trip_a !== (TRIP ? 16'd10 : 16'd0)) begin bad++; $display("FAIL dist_trip got=%0d want=%0d", trip_a, TRIP ? 10 : 0); end
        if (fuel_a !== 8'd97) begin bad++; $display("FAIL dist_fuel got=%0d want=97", fuel_a); end
        is_side_brake = 1'b1;
        repeat (100) one_tick(1'b0);
        total += 3;
        if (odo_a !== 32'd1)  begin bad++; $display("FAIL brake_odo got=%0d want=1", odo_a); end
        if (km_a - ka !== 1)  begin bad++; $display("FAIL brake_km_pulses got=%0d want=1", km_a - ka); end
        if (fuel_a !== 8'd96) begin bad++; $display("FAIL brake_fuel got=%0d want=96", fuel_a); end
        is_side_brake = 1'b0;
    endtask

    task automatic test_idle_burn();
        speed = 8'd255;
        for (int i = 0; i < 1000 && m_fuel > 15; i++) one_tick(1'b0);
        total += 2;
        if (fuel_a !== 8'(m_fuel)) begin bad++; $display("FAIL fast_burn_fuel got=%0d want=%0d", fuel_a, m_fuel); end
        if (odo_a !== m_odo_a)     begin bad++; $display("FAIL fast_burn_odo got=%0d want=%0d", odo_a, m_odo_a); end
        speed = 8'd0;
        for (int i = 0; i < 600 && m_fuel > 14; i++) one_tick(1'b0);
        total += 2;
        if (fuel_a !== 8'd14) begin bad++; $display("FAIL idle_fuel got=%0d want=14", fuel_a); end
        if (low_a !== 1'b0)   begin bad++; $display("FAIL low_early got=%0b want=0", low_a); end
        @(negedge clk);
        total++;
        if (low_a !== 1'b1)   begin bad++; $display("FAIL low_late got=%0b want=1", low_a); end
        repeat (499) one_tick(1'b0);
        total++;
        if (fuel_a !== 8'd14) begin bad++; $display("FAIL idle_499 got=%0d want=14", fuel_a); end
        one_tick(1'b0);
        total++;
        if (fuel_a !== 8'd13) begin bad++; $display("FAIL idle_500 got=%0d want=13", fuel_a); end
    endtask

    task automatic test_starvation();
        int unsigned saved;
        int ka;
        speed = 8'd255;
        for (int i = 0; i < 200 && m_fuel > 0; i++) one_tick(1'b0);
        total++;
        if (fuel_a !== 8'd0)  begin bad++; $display("FAIL starve_fuel got=%0d want=0", fuel_a); end
        @(negedge clk);
        total++;
        if (empty_a !== 1'b1) begin bad++; $display("FAIL starve_empty got=%0b want=1", empty_a); end
        saved = m_odo_a; ka = km_a;
        repeat (20) one_tick(1'b0);
        total += 2;
        if (odo_a !== saved)  begin bad++; $display("FAIL starve_odo got=%0d want=%0d", odo_a, saved); end
        if (km_a !== ka)      begin bad++; $display("FAIL starve_km got=%0d want=%0d", km_a, ka); end
        refuel_req = 1'b1;
        repeat (10) one_tick(1'b0);
        total++;
        if (fuel_a !== 8'd0)  begin bad++; $display("FAIL refuel_engine_on got=%0d want=0", fuel_a); end
        engine_on = 1'b0; refuel_req = 1'b0;
        repeat (2) one_tick(1'b0);
        total++;
        if (fuel_a !== 8'd0)  begin bad++; $display("FAIL off_after_starve got=%0d want=0", fuel_a); end
    endtask

    task automatic test_refuel();
        refuel_req = 1'b1;
        repeat (50) one_tick(1'b0);
        total += 2;
        if (fuel_a !== 8'd50) begin bad++; $display("FAIL refuel_50 got=%0d want=50", fuel_a); end
        if (empty_a !== 1'b0) begin bad++; $display("FAIL refuel_empty got=%0b want=0", empty_a); end
        repeat (200) one_tick(1'b0);
        total += 2;
        if (fuel_a !== 8'd100) begin bad++; $display("FAIL refuel_sat got=%0d want=100", fuel_a); end
        if (low_a !== 1'b0)    begin bad++; $display("FAIL refuel_low got=%0b want=0", low_a); end
        refuel_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit done;
        done = 1'b0;
        engine_on = 1'b1; speed = 8'd36;
        for (int i = 0; i < 12 && !done; i++) begin
            done = m_dist + 36 >= 360;
            one_tick(done);
        end
        total++;
        if (trip_a !== 16'd0) begin bad++; $display("FAIL trip_coincident got=%0d want=0", trip_a); end
        repeat (10) one_tick(1'b0);
        total += 3;
        if (trip_a !== (TRIP ? 16'd1 : 16'd0)) begin bad++; $display("FAIL trip_resume got=%0d want=%0d", trip_a, TRIP ? 1 : 0); end
        if (odo_a !== m_odo_a) begin bad++; $display("FAIL final_odo_a got=%0d want=%0d", odo_a, m_odo_a); end
        if (fuel_a !== 8'(m_fuel)) begin bad++; $display("FAIL final_fuel got=%0d want=%0d", fuel_a, m_fuel); end
    endtask

    initial begin
        test_reset();
        test_distance();
        test_idle_burn();
        test_starvation();
        test_refuel();
        test_back_to_back();
        repeat (3) @(negedge clk);
        total += 2;
        if (q_a.size() != 0) begin bad++; $display("FAIL km_a missing pulses got=0 want=%0d", q_a.size()); end
        if (q_b.size() != 0) begin bad++; $display("FAIL km_b missing pulses got=0 want=%0d", q_b.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
